// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external, registered ALU between two requesters. Only one
// operation is in flight at a time. The operation runs IDLE -> EXEC -> RESP:
//   IDLE : pick a requester, latch its op/operands on the handshake
//   EXEC : wait ALU_LATENCY edges for the ALU, then capture alu_out
//   RESP : present the result to the owner until it is consumed
// When both requesters are valid on the same cycle, the one that was not
// served last wins, so the two requesters take turns.
//
// States:
//   state | meaning
//   IDLE  | no operation outstanding; grant evaluated every cycle
//   EXEC  | op/operands latched and driving the ALU; latency counter running
//   RESP  | result captured; rsp[owner]_valid held until rsp[owner]_ready
//
// Parameters:
//   WORD_WIDTH  - operand/result width
//   ALU_LATENCY - edges from ALU input change to valid alu_out (1..15)
//
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   reqN_valid/ready       - request handshake for requester N (ready is
//                            combinational, only in IDLE)
//   reqN_op/a/b            - op code and operands of requester N
//   rspN_valid/ready       - response handshake for requester N
//   rspN_data              - result register (same value on both ports)
//   alu_op/alu_in1/alu_in2 - drive to the shared ALU, from latched registers
//   alu_out                - registered ALU result
//   busy                   - high whenever the FSM is not in IDLE
//   done_count             - completed-operation counter (wraps)
//
// Op codes are passed through to the ALU unchanged; this block never
// interprets them.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WORD_WIDTH  = 16,
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [2:0]            req0_op,
  input  logic [WORD_WIDTH-1:0] req0_a,
  input  logic [WORD_WIDTH-1:0] req0_b,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [WORD_WIDTH-1:0] rsp0_data,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [2:0]            req1_op,
  input  logic [WORD_WIDTH-1:0] req1_a,
  input  logic [WORD_WIDTH-1:0] req1_b,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [WORD_WIDTH-1:0] rsp1_data,

  output logic [2:0]            alu_op,
  output logic [WORD_WIDTH-1:0] alu_in1,
  output logic [WORD_WIDTH-1:0] alu_in2,
  input  logic [WORD_WIDTH-1:0] alu_out,

  output logic                  busy,
  output logic [15:0]           done_count
);

  // The latency counter is 4 bits wide, so anything outside 1..15 would
  // silently truncate; stop elaboration instead.
  generate
    if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_latency
      $error("alu_arbiter: ALU_LATENCY must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic                  owner;       // requester that owns the current op
  logic                  last_grant;  // requester served most recently
  logic [3:0]            lat_cnt;
  logic [2:0]            op_q;
  logic [WORD_WIDTH-1:0] a_q;
  logic [WORD_WIDTH-1:0] b_q;
  logic [WORD_WIDTH-1:0] result_q;
  logic [15:0]           done_count_q;
  logic                  busy_q;
  logic                  rsp0_valid_q;
  logic                  rsp1_valid_q;

  logic                  grant0;
  logic                  grant1;
  logic                  accept0;
  logic                  accept1;
  logic                  owner_rsp_ready;

  // Grant is recomputed every IDLE cycle from the current valids, so a
  // requester that drops valid before being accepted leaves no trace.
  // On a tie, last_grant==1 means requester 1 went last, so requester 0 wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;

  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      lat_cnt      <= 4'd0;
      op_q         <= 3'd0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      done_count_q <= 16'd0;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept0 || accept1) begin
            owner   <= accept1;
            op_q    <= accept1 ? req1_op : req0_op;
            a_q     <= accept1 ? req1_a  : req0_a;
            b_q     <= accept1 ? req1_b  : req0_b;
            lat_cnt <= LAT_LOAD;
            busy_q  <= 1'b1;
            state   <= EXEC;
          end
        end

        // The counter reaches zero ALU_LATENCY edges after acceptance, which
        // is exactly when alu_out reflects the latched inputs; capturing on
        // the following edge puts rsp valid at ALU_LATENCY+1 edges.
        EXEC: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            result_q     <= alu_out;
            rsp0_valid_q <= !owner;
            rsp1_valid_q <= owner;
            state        <= RESP;
          end
        end

        RESP: begin
          if (owner_rsp_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            last_grant   <= owner;
            done_count_q <= done_count_q + 16'd1;
            state        <= IDLE;
          end
        end

        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // ALU inputs come only from the latched copies so they stay frozen for the
  // whole of EXEC regardless of what the requesters do.
  assign alu_op     = op_q;
  assign alu_in1    = a_q;
  assign alu_in2    = b_q;

  assign rsp0_data  = result_q;
  assign rsp1_data  = result_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign busy       = busy_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int W   = 16;
  localparam int LAT = 1;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_MUL   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_XOR   = 3'd5;
  localparam logic [2:0] ALU_SLT   = 3'd6;
  localparam logic [2:0] ALU_SHIFT = 3'd7;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [2:0]    req0_op, req1_op, alu_op;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0]  rsp0_data, rsp1_data;
  logic [W-1:0]  alu_in1, alu_in2, alu_out;
  logic          busy;
  logic [15:0]   done_count;

  int            n_vec;
  int            n_miss;
  logic [15:0]   exp_done;

  alu_arbiter #(.WORD_WIDTH(W), .ALU_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
    .busy(busy), .done_count(done_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External ALU: one register stage (LAT = 1).
  always @(posedge clk) begin
    case (alu_op)
      ALU_ADD:   alu_out <= alu_in1 + alu_in2;
      ALU_SUB:   alu_out <= alu_in1 - alu_in2;
      ALU_MUL:   alu_out <= alu_in1 * alu_in2;
      ALU_AND:   alu_out <= alu_in1 & alu_in2;
      ALU_OR:    alu_out <= alu_in1 | alu_in2;
      ALU_XOR:   alu_out <= alu_in1 ^ alu_in2;
      ALU_SLT:   alu_out <= ($signed(alu_in1) < $signed(alu_in2)) ? 16'd1 : 16'd0;
      default:   alu_out <= alu_in1 << alu_in2;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input bit who);
    return who ? req1_ready : req0_ready;
  endfunction

  function automatic logic rspv(input bit who);
    return who ? rsp1_valid : rsp0_valid;
  endfunction

  function automatic logic [W-1:0] rspd(input bit who);
    return who ? rsp1_data : rsp0_data;
  endfunction

  task automatic drive(input bit who, input logic v, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (who) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Called #1 after the accepting edge; returns edges until rsp valid.
  task automatic wait_rsp(input bit who, output int lat);
    lat = 0;
    while (!rspv(who) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_rsp(input bit who, input string nm);
    if (who) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    exp_done = exp_done + 16'd1;
    chk({nm, "_done_count"}, done_count, exp_done);
    chk({nm, "_rsp_dropped"}, rspv(who), 1'b0);
  endtask

  task automatic run_op(input bit who, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input string nm);
    int k;
    int lat;
    @(negedge clk);
    drive(who, 1'b1, op, a, b);
    #1;
    k = 0;
    while (!rdy(who) && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk({nm, "_grant"}, rdy(who), 1'b1);
    @(posedge clk); #1;
    drive(who, 1'b0, op, a, b);
    wait_rsp(who, lat);
    chk({nm, "_latency"}, lat, LAT + 1);
    chk({nm, "_data"}, rspd(who), exp);
    finish_rsp(who, nm);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_done = 16'd0;
  endtask

  typedef struct {
    bit           who;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vt[7];

  initial begin
    int  lat;
    bit  bad;
    bit  seen;
    n_vec = 0;
    n_miss = 0;
    exp_done = 16'd0;

    vt[0] = '{1'b0, ALU_ADD,   16'd5,      16'd7,      16'd12};
    vt[1] = '{1'b1, ALU_SUB,   16'd100,    16'd1,      16'd99};
    vt[2] = '{1'b0, ALU_MUL,   16'd3,      16'd5,      16'd15};
    vt[3] = '{1'b1, ALU_SHIFT, 16'd1,      16'd4,      16'd16};
    vt[4] = '{1'b0, ALU_SLT,   16'd9,      16'd2,      16'd0};
    vt[5] = '{1'b1, ALU_AND,   16'hF0F0,   16'hFF00,   16'hF000};
    vt[6] = '{1'b0, ALU_SUB,   16'd0,      16'd1,      16'hFFFF};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0, '0, '0);
    drive(1'b1, 1'b0, 3'd0, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    #12;
    chk("rst_busy",   busy, 1'b0);
    chk("rst_rdy0",   req0_ready, 1'b0);
    chk("rst_rdy1",   req1_ready, 1'b0);
    chk("rst_rspv",   {rsp0_valid, rsp1_valid}, 2'b00);
    chk("rst_alu",    {alu_op, alu_in1, alu_in2}, '0);
    chk("rst_data",   {rsp0_data, rsp1_data}, '0);
    chk("rst_done",   done_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single operations, alternating requesters.
    for (int i = 0; i < 7; i++)
      run_op(vt[i].who, vt[i].op, vt[i].a, vt[i].b, vt[i].exp, $sformatf("vec%0d", i));

    // Tie right after reset: req0 first, req1 held off until req0 completes.
    pulse_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, ALU_SUB, 16'd15, 16'd4);
    drive(1'b1, 1'b1, ALU_MUL, 16'd4, 16'd9);
    #1;
    chk("tie_rdy0", req0_ready, 1'b1);
    chk("tie_rdy1", req1_ready, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    bad = 1'b0;
    lat = 0;
    while (!rsp0_valid && lat < 40) begin
      if (req1_ready) bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (req1_ready) bad = 1'b1;
    chk("tie_lat0", lat, LAT + 1);
    chk("tie_data0", rsp0_data, 16'd11);
    chk("tie_rspv1_low", rsp1_valid, 1'b0);
    finish_rsp(1'b0, "tie0");
    chk("tie_rdy1_held_off", bad, 1'b0);
    chk("tie_rdy1_after", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp(1'b1, lat);
    chk("tie_data1", rsp1_data, 16'd36);
    finish_rsp(1'b1, "tie1");

    // Both held valid: grants alternate 0,1,0,1.
    drive(1'b0, 1'b1, ALU_SLT, 16'd5, 16'd7);
    drive(1'b1, 1'b1, ALU_AND, 16'd9, 16'd12);
    for (int i = 0; i < 4; i++) begin
      bit ew;
      ew = bit'(i % 2);
      #1;
      chk($sformatf("rr%0d_grant", i), {rdy(ew), rdy(!ew)}, 2'b10);
      @(posedge clk); #1;
      wait_rsp(ew, lat);
      chk($sformatf("rr%0d_data", i), rspd(ew), ew ? 16'd8 : 16'd1);
      finish_rsp(ew, $sformatf("rr%0d", i));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Response back-pressure on requester 1.
    @(negedge clk);
    drive(1'b1, 1'b1, ALU_XOR, 16'd9, 16'd12);
    #1;
    chk("bp_grant", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp(1'b1, lat);
    drive(1'b0, 1'b1, ALU_ADD, 16'd2, 16'd2);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!rsp1_valid || rsp1_data !== 16'd5 || req0_ready || !busy) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("bp_stable", bad, 1'b0);
    chk("bp_data", rsp1_data, 16'd5);
    finish_rsp(1'b1, "bp");
    chk("bp_rdy0_after", req0_ready, 1'b1);
    req0_valid = 1'b0;

    // Reset mid-EXEC abandons the operation.
    @(negedge clk);
    drive(1'b0, 1'b1, ALU_SHIFT, 16'd5, 16'd3);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("rx_busy", busy, 1'b1);
    chk("rx_alu_in", {alu_op, alu_in1, alu_in2}, {ALU_SHIFT, 16'd5, 16'd3});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rx_busy_rst", busy, 1'b0);
    chk("rx_rspv_rst", {rsp0_valid, rsp1_valid}, 2'b00);
    chk("rx_alu_rst", {alu_op, alu_in1, alu_in2}, '0);
    chk("rx_data_rst", {rsp0_data, rsp1_data}, '0);
    chk("rx_done_rst", done_count, 16'd0);
    exp_done = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp0_valid || rsp1_valid || busy) seen = 1'b1;
    end
    chk("rx_no_rsp", seen, 1'b0);
    run_op(1'b0, ALU_ADD, 16'd1, 16'd1, 16'd2, "rx_add");

    // done_count wrap.
    @(negedge clk);
    force dut.done_count_q = 16'hFFFF;
    #1;
    release dut.done_count_q;
    exp_done = 16'hFFFF;
    chk("wrap_preload", done_count, 16'hFFFF);
    run_op(1'b1, ALU_OR, 16'd9, 16'd12, 16'd13, "wrap");
    chk("wrap_zero", done_count, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
